// File: rtl/iter_muldiv_alu.sv
// iter_muldiv_alu: clocked ALU with HI/LO, iterative signed/unsigned multiply and divide, valid/ready issue
module iter_muldiv_alu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [4:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         flush,
  output logic         resp_valid,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         div_zero,
  output logic         busy,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);
  localparam int SW = $clog2(W);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_d;
  logic [2*W-1:0] acc, mul_nx, div_nx, prod;
  logic [W-1:0] b_mag, a_raw, a_mag, bm, sum, dif, alu, q, r;
  logic [W:0] msum, dt, dd;
  logic [SW-1:0] cnt, sh;
  logic neg_q, neg_r, dz, accept, is_mul, is_div, sgn, a_neg, b_neg, ovf, last;
  assign req_ready = state == IDLE;
  assign busy = ~req_ready;
  assign accept = req_valid & req_ready;
  assign is_mul = op == 5'd14 || op == 5'd15;
  assign is_div = op == 5'd16 || op == 5'd17;
  assign sgn = op == 5'd14 || op == 5'd16;
  assign a_neg = sgn & in1[W-1];
  assign b_neg = sgn & in2[W-1];
  assign a_mag = a_neg ? -in1 : in1;
  assign bm = b_neg ? -in2 : in2;
  assign sh = in1[SW-1:0];
  assign sum = in1 + in2;
  assign dif = in1 - in2;
  assign last = cnt == SW'(W - 1);
  assign ovf = op == 5'd1 ? (in1[W-1] == in2[W-1]) && (sum[W-1] != in1[W-1]) :
               op == 5'd3 ? (in1[W-1] != in2[W-1]) && (dif[W-1] != in1[W-1]) : 1'b0;
  always_comb begin
    alu = '0;
    case (op)
      5'd0, 5'd1: alu = sum;
      5'd2, 5'd3: alu = dif;
      5'd4:  alu = W'($signed(in1) < $signed(in2));
      5'd5:  alu = W'(in1 < in2);
      5'd6:  alu = in1 & in2;
      5'd7:  alu = in1 | in2;
      5'd8:  alu = in1 ^ in2;
      5'd9:  alu = ~(in1 | in2);
      5'd10: alu = in2 << sh;
      5'd11: alu = in2 >> sh;
      5'd12: alu = $signed(in2) >>> sh;
      5'd13: alu = W'(in1 == in2);
      5'd18: alu = hi_o;
      5'd19: alu = lo_o;
      default: alu = '0;
    endcase
  end
  // shift-add step: add multiplicand to upper half when multiplier LSB set, then shift right
  assign msum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_nx = {msum, acc[W-1:1]};
  assign prod = neg_q ? -mul_nx : mul_nx;
  // restoring step: acc = {remainder, dividend/quotient}
  assign dt = {acc[2*W-1:W], acc[W-1]};
  assign dd = dt - {1'b0, b_mag};
  assign div_nx = dd[W] ? {dt[W-1:0], acc[W-2:0], 1'b0} : {dd[W-1:0], acc[W-2:0], 1'b1};
  assign q = acc[W-1:0];
  assign r = acc[2*W-1:W];
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = !accept ? IDLE : is_mul ? MUL : is_div ? DIV : IDLE;
      MUL:  state_d = flush || last ? IDLE : MUL;
      DIV:  state_d = flush ? IDLE : last ? FIX : DIV;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      b_mag <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
      result <= '0;
      resp_valid <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      state <= state_d;
      resp_valid <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      if (accept) begin
        result <= alu;
        resp_valid <= !(is_mul || is_div);
        overflow <= ovf;
        acc <= {{W{1'b0}}, a_mag};
        b_mag <= bm;
        a_raw <= in1;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz <= in2 == '0;
        cnt <= '0;
        if (op == 5'd20) hi_o <= in1;
        if (op == 5'd21) lo_o <= in1;
      end else if (state == MUL && !flush) begin
        acc <= mul_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          {hi_o, lo_o} <= prod;
          resp_valid <= 1'b1;
          result <= '0;
        end
      end else if (state == DIV && !flush) begin
        acc <= div_nx;
        cnt <= cnt + 1'b1;
      end else if (state == FIX && !flush) begin
        lo_o <= dz ? '1 : neg_q ? -q : q;
        hi_o <= dz ? a_raw : neg_r ? -r : r;
        div_zero <= dz;
        resp_valid <= 1'b1;
        result <= '0;
      end
    end
  end
endmodule

// File: tb/tb_iter_muldiv_alu.sv
// tb_iter_muldiv_alu: directed vectors with hand-computed results for iter_muldiv_alu (W=32)
module tb_iter_muldiv_alu;
  logic clk = 0, rst_n = 0, req_valid = 0, flush = 0;
  logic [4:0] op = '0;
  logic [31:0] in1 = '0, in2 = '0;
  logic req_ready, resp_valid, overflow, div_zero, busy;
  logic [31:0] result, hi_o, lo_o;
  logic [31:0] r_res;
  logic r_ovf, r_dz, seen;
  int lat, errors = 0, checks = 0;
  iter_muldiv_alu #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .in1(in1), .in2(in2), .flush(flush), .resp_valid(resp_valid), .result(result),
    .overflow(overflow), .div_zero(div_zero), .busy(busy), .hi_o(hi_o), .lo_o(lo_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; in1 = a; in2 = b; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; in1 = '0; in2 = '0;
  endtask
  task automatic run(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r_res = result; r_ovf = overflow; r_dz = div_zero;
  endtask
  task automatic watch(input int n);
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1;
    end
  endtask
  initial begin
    #12;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_result", result, 0);
    check("rst_flags", {resp_valid, overflow, div_zero}, 0);
    check("rst_ready", {req_ready, busy}, 2'b10);
    @(negedge clk); rst_n = 1;
    run(5'd1, 32'h7FFFFFFF, 32'd1);
    check("add_lat", lat, 1);
    check("add_res", r_res, 32'h80000000);
    check("add_ovf", r_ovf, 1);
    run(5'd0, 32'h7FFFFFFF, 32'd1);
    check("addu_res", r_res, 32'h80000000);
    check("addu_ovf", r_ovf, 0);
    run(5'd3, 32'h80000000, 32'd1);
    check("sub_res", r_res, 32'h7FFFFFFF);
    check("sub_ovf", r_ovf, 1);
    run(5'd2, 32'd3, 32'd5);
    check("subu_res", {r_ovf, r_res}, {1'b0, 32'hFFFFFFFE});
    run(5'd4, 32'hFFFFFFFF, 32'd1);
    check("slt", r_res, 1);
    run(5'd5, 32'hFFFFFFFF, 32'd1);
    check("sltu", r_res, 0);
    run(5'd6, 32'h0000F0F0, 32'h0000FF00);
    check("and", r_res, 32'h0000F000);
    run(5'd8, 32'h0000F0F0, 32'h0000FF00);
    check("xor", r_res, 32'h00000FF0);
    run(5'd9, 32'd0, 32'd0);
    check("nor", r_res, 32'hFFFFFFFF);
    run(5'd10, 32'd4, 32'd1);
    check("sll", r_res, 32'd16);
    run(5'd11, 32'd4, 32'h80000000);
    check("srl", r_res, 32'h08000000);
    run(5'd12, 32'd31, 32'h80000000);
    check("sra", r_res, 32'hFFFFFFFF);
    run(5'd13, 32'd5, 32'd5);
    check("seq", r_res, 1);
    run(5'd25, 32'd5, 32'd5);
    check("op25", {r_ovf, r_dz, r_res}, 0);
    issue(5'd14, 32'hFFFFFFFD, 32'd7);
    check("mult_busy", {req_ready, busy}, 2'b01);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("mult_lat", lat, 33);
    check("mult_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFEB);
    check("mult_res", result, 0);
    run(5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_hilo", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);
    run(5'd16, 32'hFFFFFFF9, 32'd2);
    check("div_lat", lat, 34);
    check("div_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    check("div_dz", r_dz, 0);
    run(5'd17, 32'd100, 32'd7);
    check("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
    run(5'd19, 32'd0, 32'd0);
    check("mflo", r_res, 32'd14);
    run(5'd17, 32'd5, 32'd0);
    check("dz_flag", r_dz, 1);
    check("dz_hilo", {hi_o, lo_o}, {32'd5, 32'hFFFFFFFF});
    run(5'd16, 32'h80000000, 32'hFFFFFFFF);
    check("min_hilo", {hi_o, lo_o}, 64'h00000000_80000000);
    check("min_dz", r_dz, 0);
    run(5'd20, 32'hA5, 32'd0);
    check("mthi_lat", lat, 1);
    check("mthi_hi", hi_o, 32'hA5);
    issue(5'd14, 32'hFFFFFFFD, 32'd7);
    repeat (3) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check("flush_ready", req_ready, 1);
    watch(40);
    check("flush_noresp", seen, 0);
    check("flush_hi", hi_o, 32'hA5);
    run(5'd18, 32'd0, 32'd0);
    check("mfhi", r_res, 32'hA5);
    run(5'd21, 32'h1234, 32'd0);
    check("mtlo_lo", lo_o, 32'h1234);
    issue(5'd14, 32'hFFFFFFFD, 32'd7);
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("amid_hilo", {hi_o, lo_o}, 0);
    check("amid_ready", req_ready, 1);
    @(negedge clk); rst_n = 1;
    watch(40);
    check("amid_noresp", seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
